// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one 16-byte block from memory1c into the data array, then writes the tag.
// Latency: fill starts the edge after a miss; stall lasts WORDS_PER_BLOCK+1 cycles.
// Backpressure: none accepted; the pipeline is held via fsm_busy until the tag is written.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_WIDTH-1:0]              miss_address,
    input  logic [15:0]                        mem_data_out,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic                               fsm_busy,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_sel,
    output logic [15:0]                        cache_data,
    output logic                               write_tag_array
);

    localparam int CW  = $clog2(WORDS_PER_BLOCK);
    localparam int OFF = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]   base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base  <= miss_address & ~OFF_MASK;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (cnt == LAST_WORD) begin
                        cnt   <= '0;
                        state <= TAG;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TAG:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic in_fill;
    assign in_fill = (state == FILL);

    // Block offset is OR-ed into cleared low bits, so the walk can never carry into the tag.
    assign mem_addr         = in_fill ? (base | {{(ADDR_WIDTH-OFF){1'b0}}, cnt, 1'b0}) : '0;
    assign mem_enable       = in_fill;
    assign mem_wr           = 1'b0;
    assign fsm_busy         = in_fill || (state == TAG);
    assign write_data_array = in_fill;
    assign word_sel         = in_fill ? cnt : '0;
    assign cache_data       = in_fill ? mem_data_out : 16'h0000;
    assign write_tag_array  = (state == TAG);

endmodule
